icache_refill: RTL and testbench
================================

# icache_refill

Line-refill engine for the instruction cache. On a miss it fetches one cache line from the memory side and writes it word by word into the data `ram_NxM` instance. It then writes the tag/valid `ram_NxM` instance. It sits between the cache lookup logic, which issues the miss, and the two storage RAMs, which it drives directly.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: byte address width.
- `DATA_WIDTH`, 32: word width; must be 32.
- `N_LINES`, 8: cache lines; power of two, ≥2.
- `WORDS_PER_LINE`, 4: words per line; power of two, ≥2.
- Derived: `IDX_W`=clog2(N_LINES), `OFS_W`=clog2(WORDS_PER_LINE), `TAG_W`=ADDR_WIDTH-IDX_W-OFS_W-2.

Ports (reset is asynchronous, active-low):
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `miss_valid` in 1: lookup requests a refill.
- `miss_addr` in ADDR_WIDTH: byte address that missed.
- `miss_ready` out 1: engine idle; miss accepted when valid&&ready.
- `mem_req_valid` out 1: line read request to memory.
- `mem_req_addr` out ADDR_WIDTH: line-aligned address (low OFS_W+2 bits zero).
- `mem_req_ready` in 1: memory accepts request.
- `mem_rsp_valid` in 1: one data beat present.
- `mem_rsp_data` in DATA_WIDTH: beat data, line words in ascending order.
- `data_ram_addr` out IDX_W+OFS_W: {index, word counter}.
- `data_ram_data` out DATA_WIDTH: word to write.
- `data_ram_we` out 1: data RAM write enable.
- `tag_ram_addr` out IDX_W: line index.
- `tag_ram_data` out TAG_W+1: {valid, tag}.
- `tag_ram_we` out 1: tag RAM write enable.
- `refill_done` out 1: one-cycle pulse when the line becomes valid.

## Operation
- FSM states: IDLE, INVAL, REQ, RECV, COMMIT.
- **IDLE**
  - `miss_ready`=1.
  - On accept, latch tag = addr[ADDR_WIDTH-1 -: TAG_W] and index = addr[OFS_W+2 +: IDX_W].
  - Clear the beat counter and go to INVAL.
- **INVAL** (1 cycle)
  - `tag_ram_we`=1, `tag_ram_data`={0, tag}, so no stale hit occurs during the fill.
  - Go to REQ.
- **REQ**
  - `mem_req_valid`=1; hold `mem_req_addr` stable until `mem_req_ready`.
  - On handshake go to RECV.
- **RECV**
  - Each `mem_rsp_valid` cycle: `data_ram_we`=1 in the same cycle (combinational), `data_ram_addr`={index, cnt}, `data_ram_data`=`mem_rsp_data`; cnt increments.
  - The beat with cnt=WORDS_PER_LINE-1 moves the FSM to COMMIT; the counter wraps to 0.
  - Cycles without a beat: no write.
- **COMMIT** (1 cycle)
  - `tag_ram_we`=1, `tag_ram_data`={1, tag}, `refill_done`=1.
  - Go to IDLE.
- `mem_rsp_valid` outside RECV is ignored: no write, no state change.
- The tag is written valid only after all beats land, so a partially filled line is never visible as valid.
- Write enables are never high outside the states above; the data and tag write enables are never high together.

## Timing
- Reset values: FSM=IDLE, counter=0, latched tag/index=0.
- Outputs at reset: `miss_ready`=1; every other output 0.
- Minimum miss-to-done: accept edge, INVAL 1, REQ ≥1, RECV ≥WORDS_PER_LINE, COMMIT 1. With zero-wait memory, `refill_done` rises WORDS_PER_LINE+3 cycles after acceptance.
- `miss_ready` drops in the cycle after acceptance and returns high the cycle after COMMIT. There is no back-to-back acceptance.
- Reset asserted mid-refill:
  - Immediate return to IDLE; all enables drop asynchronously.
  - The line stays invalid because INVAL already ran.
  - RAM contents are not cleared.

## Structure
- Package `icache_pkg` holds:
  - the state enum;
  - width helper localparams (IDX_W, OFS_W, TAG_W), so that the lookup and refill logic agree on address slicing.
- Single module; the beat counter and FSM are inline. No sub-module is warranted.
- The RAMs are instantiated by the parent, not inside this block.

## Test plan
Defaults throughout (ADDR_WIDTH=32, N_LINES=8, WORDS_PER_LINE=4, TAG_W=25).
- **Reset:** hold `rst_n`=0 → `miss_ready`=1, all other outputs 0.
- **Basic refill:** miss 0x0000_1234, zero-wait memory, beats 0xA0..0xA3 →
  - tag write {0,25'h24} @ index 3;
  - `mem_req_addr`=0x0000_1230;
  - data writes to addresses 12..15 with 0xA0..0xA3;
  - tag write {1,25'h24};
  - `refill_done` exactly 7 cycles after acceptance.
- **Stalled memory:** `mem_req_ready` low 5 cycles, then beats with 2-cycle gaps → request held stable, exactly 4 data writes, no write in gap cycles.
- **Busy:** `miss_valid` held high during a refill → `miss_ready`=0 throughout; a second refill starts only after `refill_done`.
- **Spurious beat:** `mem_rsp_valid` pulsed in IDLE → no RAM writes, stays IDLE.
- **Reset mid-fill:** assert `rst_n` low after 2 beats → enables drop immediately, no valid tag write. A following refill of the same line completes normally.

Source files
------------

// File: rtl/icache_pkg.sv
// icache_pkg: shared definitions for the instruction cache.
// Holds the refill FSM state encoding and the default geometry. The lookup
// and refill logic both slice addresses with these widths, so they agree on
// which address bits form the tag, the index and the word offset.
package icache_pkg;

    localparam int unsigned ADDR_WIDTH_DEF     = 32;
    localparam int unsigned DATA_WIDTH_DEF     = 32;
    localparam int unsigned N_LINES_DEF        = 8;
    localparam int unsigned WORDS_PER_LINE_DEF = 4;

    // Default address slicing: {tag, index, word offset, byte offset[1:0]}.
    localparam int unsigned IDX_W = $clog2(N_LINES_DEF);
    localparam int unsigned OFS_W = $clog2(WORDS_PER_LINE_DEF);
    localparam int unsigned TAG_W = ADDR_WIDTH_DEF - IDX_W - OFS_W - 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INVAL  = 3'd1,
        ST_REQ    = 3'd2,
        ST_RECV   = 3'd3,
        ST_COMMIT = 3'd4
    } refill_state_e;

endpackage

// File: rtl/icache_refill.sv
// icache_refill: line-refill engine for the instruction cache.
// On an accepted miss it invalidates the target line's tag, requests the
// line from memory, writes each returned beat into the data RAM, then marks
// the tag valid and pulses refill_done.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   miss_valid/addr/ready       miss request from the lookup logic
//   mem_req_valid/addr/ready    line read request to memory (line aligned)
//   mem_rsp_valid/data          returned beats, ascending word order
//   data_ram_addr/data/we       data RAM write port, addr = {index, word}
//   tag_ram_addr/data/we        tag RAM write port, data = {valid, tag}
//   refill_done                 one-cycle pulse when the line turns valid
module icache_refill
    import icache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int unsigned N_LINES        = N_LINES_DEF,
    parameter int unsigned WORDS_PER_LINE = WORDS_PER_LINE_DEF,
    localparam int unsigned IDX_BITS      = $clog2(N_LINES),
    localparam int unsigned OFS_BITS      = $clog2(WORDS_PER_LINE),
    localparam int unsigned TAG_BITS      = ADDR_WIDTH - IDX_BITS - OFS_BITS - 2
) (
    input  logic                         clk,
    input  logic                         rst_n,

    input  logic                         miss_valid,
    input  logic [ADDR_WIDTH-1:0]        miss_addr,
    output logic                         miss_ready,

    output logic                         mem_req_valid,
    output logic [ADDR_WIDTH-1:0]        mem_req_addr,
    input  logic                         mem_req_ready,

    input  logic                         mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]        mem_rsp_data,

    output logic [IDX_BITS+OFS_BITS-1:0] data_ram_addr,
    output logic [DATA_WIDTH-1:0]        data_ram_data,
    output logic                         data_ram_we,

    output logic [IDX_BITS-1:0]          tag_ram_addr,
    output logic [TAG_BITS:0]            tag_ram_data,
    output logic                         tag_ram_we,

    output logic                         refill_done
);

    localparam logic [OFS_BITS-1:0] LAST_BEAT = OFS_BITS'(WORDS_PER_LINE - 1);

    refill_state_e         r_state;
    logic [OFS_BITS-1:0]   r_cnt;
    logic [TAG_BITS-1:0]   r_tag;
    logic [IDX_BITS-1:0]   r_idx;
    logic                  r_miss_ready;
    logic                  r_req_valid;
    logic                  r_tag_we;
    logic                  r_tag_valid;
    logic                  r_done;

    logic                  w_beat;
    logic                  w_unused;

    // Byte and word offset bits of the miss address are not needed here.
    assign w_unused = ^miss_addr[OFS_BITS+1:0];

    // Outputs for the next state are registered here, so each one is a
    // flop that the asynchronous reset clears together with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_tag        <= '0;
            r_idx        <= '0;
            r_miss_ready <= 1'b1;
            r_req_valid  <= 1'b0;
            r_tag_we     <= 1'b0;
            r_tag_valid  <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_tag_we <= 1'b0;
            r_done   <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (miss_valid) begin
                        r_tag        <= miss_addr[ADDR_WIDTH-1 -: TAG_BITS];
                        r_idx        <= miss_addr[OFS_BITS+2 +: IDX_BITS];
                        r_cnt        <= '0;
                        r_miss_ready <= 1'b0;
                        r_tag_we     <= 1'b1;
                        r_tag_valid  <= 1'b0;
                        r_state      <= ST_INVAL;
                    end
                end
                ST_INVAL: begin
                    r_req_valid <= 1'b1;
                    r_state     <= ST_REQ;
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (mem_rsp_valid) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST_BEAT) begin
                            // Tag goes valid only once every beat has landed.
                            r_tag_we    <= 1'b1;
                            r_tag_valid <= 1'b1;
                            r_done      <= 1'b1;
                            r_state     <= ST_COMMIT;
                        end
                    end
                end
                ST_COMMIT: begin
                    r_miss_ready <= 1'b1;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_miss_ready <= 1'b1;
                    r_req_valid  <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    // Data writes follow the beat in the same cycle; beats outside RECV are
    // dropped.
    assign w_beat = (r_state == ST_RECV) && mem_rsp_valid;

    assign miss_ready    = r_miss_ready;
    assign mem_req_valid = r_req_valid;
    assign mem_req_addr  = r_req_valid ? {r_tag, r_idx, {(OFS_BITS + 2){1'b0}}} : '0;

    assign data_ram_we   = w_beat;
    assign data_ram_addr = w_beat ? {r_idx, r_cnt} : '0;
    assign data_ram_data = w_beat ? mem_rsp_data : '0;

    assign tag_ram_we    = r_tag_we;
    assign tag_ram_addr  = r_idx;
    assign tag_ram_data  = r_tag_we ? {r_tag_valid, r_tag} : '0;

    assign refill_done   = r_done;

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill with default geometry (TAG_W = 25).
// Inputs change 1 time unit after each rising edge; outputs are checked
// 1 time unit later, well before the falling edge.
module tb_icache_refill;

    logic        clk;
    logic        rst_n;
    logic        miss_valid;
    logic [31:0] miss_addr;
    logic        miss_ready;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic [4:0]  data_ram_addr;
    logic [31:0] data_ram_data;
    logic        data_ram_we;
    logic [2:0]  tag_ram_addr;
    logic [25:0] tag_ram_data;
    logic        tag_ram_we;
    logic        refill_done;

    int n_vec;
    int n_err;

    icache_refill dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .miss_valid    (miss_valid),
        .miss_addr     (miss_addr),
        .miss_ready    (miss_ready),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .data_ram_addr (data_ram_addr),
        .data_ram_data (data_ram_data),
        .data_ram_we   (data_ram_we),
        .tag_ram_addr  (tag_ram_addr),
        .tag_ram_data  (tag_ram_data),
        .tag_ram_we    (tag_ram_we),
        .refill_done   (refill_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Full zero-wait refill starting from IDLE at the current cycle.
    // The accept cycle is cycle 0; refill_done must be high in cycle 7 only.
    task automatic refill_zw(input logic [31:0] addr, input logic [2:0] idx,
                             input logic [24:0] tag, input logic [31:0] base,
                             input bit hold);
        miss_valid    = 1'b1;
        miss_addr     = addr;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        #1;
        check("accept_ready", {31'b0, miss_ready}, 32'd1);
        next_cycle();
        miss_valid = hold;
        #1;
        check("inval_we", {31'b0, tag_ram_we}, 32'd1);
        check("inval_idx", {29'b0, tag_ram_addr}, {29'b0, idx});
        check("inval_data", {6'b0, tag_ram_data}, {7'b0, tag});
        check("inval_ready", {31'b0, miss_ready}, 32'd0);
        next_cycle();
        #1;
        check("req_valid", {31'b0, mem_req_valid}, 32'd1);
        check("req_addr", mem_req_addr, {addr[31:4], 4'h0});
        check("req_no_tag_we", {31'b0, tag_ram_we}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = base + 32'(i);
            #1;
            check("beat_we", {31'b0, data_ram_we}, 32'd1);
            check("beat_addr", {27'b0, data_ram_addr}, {27'b0, idx, 2'(i)});
            check("beat_data", data_ram_data, base + 32'(i));
            check("beat_no_tag_we", {31'b0, tag_ram_we}, 32'd0);
            check("beat_no_done", {31'b0, refill_done}, 32'd0);
            if (hold) check("busy_ready", {31'b0, miss_ready}, 32'd0);
        end
        next_cycle();
        mem_rsp_valid = 1'b0;
        #1;
        check("commit_we", {31'b0, tag_ram_we}, 32'd1);
        check("commit_data", {6'b0, tag_ram_data}, {6'b0, 1'b1, tag});
        check("commit_done", {31'b0, refill_done}, 32'd1);
        check("commit_no_data_we", {31'b0, data_ram_we}, 32'd0);
        next_cycle();
        #1;
        check("back_idle_ready", {31'b0, miss_ready}, 32'd1);
        check("done_pulse_end", {31'b0, refill_done}, 32'd0);
    endtask

    initial begin
        int writes;
        n_vec         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        miss_valid    = 1'b0;
        miss_addr     = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;

        // Reset state.
        #12;
        check("rst_miss_ready", {31'b0, miss_ready}, 32'd1);
        check("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
        check("rst_req_addr", mem_req_addr, 32'd0);
        check("rst_data_we", {31'b0, data_ram_we}, 32'd0);
        check("rst_data_addr", {27'b0, data_ram_addr}, 32'd0);
        check("rst_data_data", data_ram_data, 32'd0);
        check("rst_tag_we", {31'b0, tag_ram_we}, 32'd0);
        check("rst_tag_addr", {29'b0, tag_ram_addr}, 32'd0);
        check("rst_tag_data", {6'b0, tag_ram_data}, 32'd0);
        check("rst_done", {31'b0, refill_done}, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // Spurious beats while idle.
        for (int i = 0; i < 2; i++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 32'hDEAD_0000 + 32'(i);
            #1;
            check("spur_data_we", {31'b0, data_ram_we}, 32'd0);
            check("spur_tag_we", {31'b0, tag_ram_we}, 32'd0);
            next_cycle();
        end
        mem_rsp_valid = 1'b0;
        #1;
        check("spur_still_idle", {31'b0, miss_ready}, 32'd1);
        check("spur_no_req", {31'b0, mem_req_valid}, 32'd0);
        next_cycle();

        // Basic refill: 0x1234 -> index 3, tag 0x24, line 0x1230.
        refill_zw(32'h0000_1234, 3'd3, 25'h24, 32'hA0, 1'b0);

        // Stalled memory: 0xABCC -> index 4, tag 0x157, line 0xABC0.
        miss_valid = 1'b1;
        miss_addr  = 32'h0000_ABCC;
        next_cycle();
        miss_valid    = 1'b0;
        mem_req_ready = 1'b0;
        #1;
        check("st_inval_idx", {29'b0, tag_ram_addr}, 32'd4);
        check("st_inval_data", {6'b0, tag_ram_data}, 32'h157);
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            #1;
            check("st_req_held", {31'b0, mem_req_valid}, 32'd1);
            check("st_req_addr", mem_req_addr, 32'h0000_ABC0);
        end
        next_cycle();
        mem_req_ready = 1'b1;
        #1;
        check("st_req_last", mem_req_addr, 32'h0000_ABC0);
        next_cycle();
        mem_req_ready = 1'b0;
        writes = 0;
        for (int b = 0; b < 4; b++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 32'hD0 + 32'(b);
            #1;
            writes += int'(data_ram_we);
            check("st_beat_addr", {27'b0, data_ram_addr}, {27'b0, 3'd4, 2'(b)});
            check("st_beat_data", data_ram_data, 32'hD0 + 32'(b));
            if (b < 3) begin
                for (int g = 0; g < 2; g++) begin
                    next_cycle();
                    mem_rsp_valid = 1'b0;
                    #1;
                    writes += int'(data_ram_we);
                    check("st_gap_we", {31'b0, data_ram_we}, 32'd0);
                    check("st_gap_tag_we", {31'b0, tag_ram_we}, 32'd0);
                end
            end
            next_cycle();
        end
        mem_rsp_valid = 1'b0;
        #1;
        check("st_write_count", 32'(writes), 32'd4);
        check("st_commit_done", {31'b0, refill_done}, 32'd1);
        check("st_commit_data", {6'b0, tag_ram_data}, 32'h200_0157);
        next_cycle();
        #1;
        check("st_idle_ready", {31'b0, miss_ready}, 32'd1);

        // Busy: miss_valid stays high; the second refill starts only after done.
        refill_zw(32'h0000_1234, 3'd3, 25'h24, 32'hE0, 1'b1);
        next_cycle();
        miss_valid = 1'b0;
        #1;
        check("busy_second_inval", {31'b0, tag_ram_we}, 32'd1);
        check("busy_second_data", {6'b0, tag_ram_data}, 32'h24);

        // Reset mid-fill: two beats land, third beat is cut by reset.
        mem_req_ready = 1'b1;
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 32'hB0 + 32'(i);
        end
        next_cycle();
        mem_rsp_data = 32'hB2;
        #1;
        check("mid_pre_rst_we", {31'b0, data_ram_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data_we", {31'b0, data_ram_we}, 32'd0);
        check("mid_rst_tag_we", {31'b0, tag_ram_we}, 32'd0);
        check("mid_rst_ready", {31'b0, miss_ready}, 32'd1);
        check("mid_rst_req", {31'b0, mem_req_valid}, 32'd0);
        next_cycle();
        check("mid_rst_no_valid", {31'b0, tag_ram_we}, 32'd0);
        check("mid_rst_no_done", {31'b0, refill_done}, 32'd0);
        mem_rsp_valid = 1'b0;
        rst_n         = 1'b1;
        next_cycle();

        refill_zw(32'h0000_1234, 3'd3, 25'h24, 32'hC0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
